// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and hazard-stall control for a 5-stage pipeline with a multi-cycle multiplier in EX.
// Optional stall statistics counter enabled by defining FWD_HAZARD_STATS_EN.
module fwd_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int MULT_LAT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_is_mult,
    output logic [1:0]            ex_sel_a,
    output logic [1:0]            ex_sel_b,
    output logic                  stall,
    output logic                  mult_busy
`ifdef FWD_HAZARD_STATS_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    localparam int CNT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

    typedef enum logic {
        RUN  = 1'b0,
        MULT = 1'b1
    } state_e;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
        logic                  is_mult;
    } stage_t;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    stage_t           ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [1:0]       sel_a_q, sel_a_d, sel_b_q, sel_b_d;
    logic             load_use;
    logic             unused_wb;

    // The youngest in-flight producer (EX before MEM) supplies the operand.
    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs,
                                           input stage_t ex_r, input stage_t mem_r);
        logic [1:0] sel;
        sel = 2'b00;
        if (rs == '0)
            sel = 2'b00;
        else if (ex_r.valid && ex_r.reg_write && (ex_r.rd == rs))
            sel = 2'b10;
        else if (mem_r.valid && mem_r.reg_write && (mem_r.rd == rs))
            sel = 2'b01;
        return sel;
    endfunction

    assign load_use = (state_q == RUN) && id_valid && ex_q.valid && ex_q.mem_read &&
                      ex_q.reg_write && (ex_q.rd != '0) &&
                      ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));

    assign stall     = (state_q == MULT) || load_use;
    assign mult_busy = (state_q == MULT);
    assign ex_sel_a  = sel_a_q;
    assign ex_sel_b  = sel_b_q;
    assign unused_wb = ^wb_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ex_d    = ex_q;
        mem_d   = mem_q;
        wb_d    = wb_q;
        sel_a_d = sel_a_q;
        sel_b_d = sel_b_q;
        if (state_q == MULT) begin
            // EX and its selects freeze while the multiplier runs; a bubble drains into MEM.
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1))
                state_d = RUN;
            mem_d = '0;
            wb_d  = mem_q;
        end else begin
            wb_d  = mem_q;
            mem_d = ex_q;
            ex_d  = '0;
            sel_a_d = 2'b00;
            sel_b_d = 2'b00;
            if (!load_use && id_valid) begin
                ex_d.valid     = 1'b1;
                ex_d.rd        = id_rd;
                ex_d.reg_write = id_reg_write;
                ex_d.mem_read  = id_mem_read;
                ex_d.is_mult   = id_is_mult;
                sel_a_d = fwd_sel(id_rs1, ex_q, mem_q);
                sel_b_d = fwd_sel(id_rs2, ex_q, mem_q);
                if (id_is_mult && (MULT_LAT > 1)) begin
                    cnt_d   = CNT_W'(MULT_LAT - 1);
                    state_d = MULT;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            sel_a_q <= 2'b00;
            sel_b_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
        end
    end

`ifdef FWD_HAZARD_STATS_EN
    logic [31:0] stall_cycles_q;

    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles_q <= '0;
        else if (stall)
            stall_cycles_q <= stall_cycles_q + 32'd1;
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule
